mem_access_stage: RTL and testbench
===================================

# mem_access_stage

MEM pipeline stage of the in-order RISC-V core. It sits between EX_MEM and the MEM/WB pipeline register. It executes loads and stores over a byte-wide memory port as a multi-cycle transfer, and holds the pipeline through the shared stall bus until the transfer finishes. Non-memory instructions pass their register write-back request straight through to MEM/WB in the same cycle.

## Interface
Parameters: none. Data width is 32 bits, register-address width is 5 bits.

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- valid_i  in  1  EX_MEM presents an instruction this cycle
- mem_op  in  4  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9–15 treated as none
- mem_addr  in  32  effective byte address
- mem_wdata  in  32  store data; low bytes are used for SB/SH
- modify_flag_i  in  1  write-back request from EX
- modify_address_i  in  5  destination register (rd)
- modify_data_i  in  32  EX result
- ram_req  out  1  byte-transfer request
- ram_wr  out  1  1 = write, 0 = read
- ram_addr  out  32  byte address
- ram_wdata  out  8  write byte
- ram_rdata  in  8  read byte, valid when ram_ready=1
- ram_ready  in  1  the byte transfer completes in a cycle with ram_req && ram_ready
- stall_req  out  1  to stall bus; freezes IF..EX_MEM and bubbles MEM/WB
- modify_flag  out  1  to MEM/WB
- modify_address  out  5  to MEM/WB
- modify_data  out  32  to MEM/WB

## Operation
- Registered state:
  - FSM: IDLE, XFER, DONE.
  - 2-bit byte counter cnt.
  - Latched op, base address, store data.
  - rd and modify_flag_i.
  - 32-bit load buffer.
- Byte count N: 1 for B/BU, 2 for H/HU, 4 for W. Byte order is little-endian.

IDLE
- If valid_i=1 and the op is none: modify_* = *_i combinationally; stall_req=0; stay in IDLE.
- If valid_i=1 and the op is a load or store: stall_req=1 combinationally. Latch all inputs, set cnt=0, clear the buffer, go to XFER. modify_* = 0.
- If valid_i=0: all outputs are 0.

XFER
- Drive ram_req=1, ram_addr=base+cnt (32-bit, wraps modulo 2^32), ram_wr=1 for stores.
- ram_wdata = store byte [8*cnt+7 : 8*cnt].
- Hold stall_req=1 and modify_*=0.
- On ram_ready=1:
  - For loads, write ram_rdata into buffer byte cnt.
  - If cnt==N-1, go to DONE; else increment cnt.
- On ram_ready=0: hold all outputs unchanged, with no limit on how long.

DONE (exactly one cycle)
- stall_req=0, ram_req=0.
- Loads: modify_flag = latched flag, modify_address = latched rd, modify_data = buffer extended from N bytes. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Stores: modify_flag=0, modify_address=0, modify_data=0.
- Inputs are ignored, because EX_MEM still shows the completed instruction. Next state is IDLE.

Other rules
- rd=0 is not special-cased; the register file discards x0 writes.
- Alignment is not checked; misaligned accesses are legal and simply use consecutive bytes.
- ram_wr, ram_addr and ram_wdata are 0 whenever ram_req=0.

## Timing
- Reset: while rst=1, and asynchronously upon assertion:
  - state=IDLE, cnt=0, latches and buffer = 0.
  - Every output is 0: ram_req, ram_wr, ram_addr, ram_wdata, stall_req, modify_flag, modify_address, modify_data.
- Reset mid-XFER: ram_req drops in the same cycle and the partial access is abandoned. After release the stage is in IDLE.
- Non-memory op: 0 added latency, no stall.
- Memory op, ram_ready tied 1:
  - Accept in cycle 0; bytes transfer in cycles 1..N; DONE in cycle N+1.
  - stall_req is high for N+1 cycles (cycles 0..N).
  - MEM/WB captures the result at the end of cycle N+1.
- Each ram_ready=0 cycle during XFER adds exactly one cycle.
- ram_req is never asserted in IDLE or DONE.
- Back-to-back memory ops: the second one is accepted in the IDLE cycle right after DONE.

## Test plan
- ALU passthrough: valid_i=1, mem_op=0, flag=1, rd=5, data=0xDEADBEEF. Required: same-cycle modify_*=(1,5,0xDEADBEEF), stall_req=0, ram_req=0.
- LW at 0x100, rd=3, ready=1, bytes 0x11,0x22,0x33,0x44. Required: ram_addr 0x100..0x103, stall_req high for 5 cycles, DONE gives modify_*=(1,3,0x44332211).
- LB and LBU at 0x20 reading 0x80. Required: modify_data=0xFFFFFF80 and 0x00000080 respectively. LH reading 0x34,0x92 gives 0xFFFF9234.
- SH, mem_wdata=0xAABB1234, addr 0xFFFFFFFF. Required: writes 0x34 to 0xFFFFFFFF, then 0x12 to 0x00000000 (wrap), ram_wr=1, DONE gives modify_flag=0.
- SW with ram_ready low for 3 cycles before byte 1. Required: ram_addr, ram_wdata and stall_req held steady, total stall = 5+3 = 8 cycles.
- LW with rst pulsed after byte 2. Required: ram_req and stall_req go to 0 immediately, no write-back occurs, and after release a passthrough op behaves normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs loads/stores as byte-serial transfers over a byte-wide RAM port
// and stalls the pipeline until the access completes; non-memory ops pass straight through.
module mem_access_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   input  logic [3:0]  mem_op,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic        modify_flag_i,
   input  logic [4:0]  modify_address_i,
   input  logic [31:0] modify_data_i,
   output logic        ram_req,
   output logic        ram_wr,
   output logic [31:0] ram_addr,
   output logic [7:0]  ram_wdata,
   input  logic [7:0]  ram_rdata,
   input  logic        ram_ready,
   output logic        stall_req,
   output logic        modify_flag,
   output logic [4:0]  modify_address,
   output logic [31:0] modify_data
);

   typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LW  = 4'd3;
   localparam logic [3:0] OP_LBU = 4'd4;
   localparam logic [3:0] OP_LHU = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [3:0]  op_q, op_d;
   logic [31:0] base_q, base_d;
   logic [31:0] wdata_q, wdata_d;
   logic [4:0]  rd_q, rd_d;
   logic        flag_q, flag_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] wshift_s;

   function automatic logic is_mem(input logic [3:0] op);
      return (op >= OP_LB) && (op <= OP_SW);
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return (op >= OP_SB) && (op <= OP_SW);
   endfunction

   // Index of the final byte of the access (N-1).
   function automatic logic [1:0] last_idx(input logic [3:0] op);
      case (op)
         OP_LH, OP_LHU, OP_SH: return 2'd1;
         OP_LW, OP_SW:         return 2'd3;
         default:              return 2'd0;
      endcase
   endfunction

   function automatic logic [31:0] extend(input logic [3:0] op, input logic [31:0] b);
      case (op)
         OP_LB:   return {{24{b[7]}}, b[7:0]};
         OP_LH:   return {{16{b[15]}}, b[15:0]};
         OP_LW:   return b;
         OP_LBU:  return {24'd0, b[7:0]};
         OP_LHU:  return {16'd0, b[15:0]};
         default: return 32'd0;
      endcase
   endfunction

   assign wshift_s = wdata_q >> {cnt_q, 3'b000};

   // State and latch registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         op_q    <= 4'd0;
         base_q  <= 32'd0;
         wdata_q <= 32'd0;
         rd_q    <= 5'd0;
         flag_q  <= 1'b0;
         buf_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         base_q  <= base_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         flag_q  <= flag_d;
         buf_q   <= buf_d;
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      op_d           = op_q;
      base_d         = base_q;
      wdata_d        = wdata_q;
      rd_d           = rd_q;
      flag_d         = flag_q;
      buf_d          = buf_q;
      ram_req        = 1'b0;
      ram_wr         = 1'b0;
      ram_addr       = 32'd0;
      ram_wdata      = 8'd0;
      stall_req      = 1'b0;
      modify_flag    = 1'b0;
      modify_address = 5'd0;
      modify_data    = 32'd0;

      case (state_q)
         IDLE: begin
            if (valid_i && is_mem(mem_op)) begin
               stall_req = 1'b1;
               op_d      = mem_op;
               base_d    = mem_addr;
               wdata_d   = mem_wdata;
               rd_d      = modify_address_i;
               flag_d    = modify_flag_i;
               cnt_d     = 2'd0;
               buf_d     = 32'd0;
               state_d   = XFER;
            end else if (valid_i) begin
               modify_flag    = modify_flag_i;
               modify_address = modify_address_i;
               modify_data    = modify_data_i;
            end else begin
               stall_req = 1'b0;
            end
         end
         XFER: begin
            ram_req   = 1'b1;
            ram_wr    = is_store(op_q);
            ram_addr  = base_q + {30'd0, cnt_q};
            ram_wdata = wshift_s[7:0];
            stall_req = 1'b1;
            if (ram_ready) begin
               if (!is_store(op_q)) begin
                  case (cnt_q)
                     2'd0:    buf_d[7:0]   = ram_rdata;
                     2'd1:    buf_d[15:8]  = ram_rdata;
                     2'd2:    buf_d[23:16] = ram_rdata;
                     2'd3:    buf_d[31:24] = ram_rdata;
                     default: buf_d        = buf_q;
                  endcase
               end else begin
                  buf_d = buf_q;
               end
               if (cnt_q == last_idx(op_q)) begin
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end else begin
               state_d = XFER;
            end
         end
         DONE: begin
            state_d = IDLE;
            if (!is_store(op_q)) begin
               modify_flag    = flag_q;
               modify_address = rd_q;
               modify_data    = extend(op_q, buf_q);
            end else begin
               modify_flag = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs read zero for the whole reset pulse, even if valid_i is presented.
      if (rst) begin
         ram_req        = 1'b0;
         ram_wr         = 1'b0;
         ram_addr       = 32'd0;
         ram_wdata      = 8'd0;
         stall_req      = 1'b0;
         modify_flag    = 1'b0;
         modify_address = 5'd0;
         modify_data    = 32'd0;
      end else begin
         stall_req = stall_req;
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: table-driven passthrough vectors plus
// scoreboarded multi-cycle load/store sequences, including wait states, wrap and reset.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic [3:0]  mem_op;
   logic [31:0] mem_addr, mem_wdata;
   logic        modify_flag_i;
   logic [4:0]  modify_address_i;
   logic [31:0] modify_data_i;
   logic        ram_req, ram_wr;
   logic [31:0] ram_addr;
   logic [7:0]  ram_wdata, ram_rdata;
   logic        ram_ready;
   logic        stall_req, modify_flag;
   logic [4:0]  modify_address;
   logic [31:0] modify_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [7:0]  wdata;
   } xact_t;

   typedef struct {
      logic        flag;
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   typedef struct {
      logic        valid;
      logic [3:0]  op;
      logic        flag;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        exp_flag;
      logic [4:0]  exp_rd;
      logic [31:0] exp_data;
   } vec_t;

   xact_t xq[$];
   wb_t   wbq[$];
   vec_t  vecs[5];

   mem_access_stage dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .mem_op(mem_op), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .modify_flag_i(modify_flag_i), .modify_address_i(modify_address_i),
      .modify_data_i(modify_data_i), .ram_req(ram_req), .ram_wr(ram_wr), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready), .stall_req(stall_req),
      .modify_flag(modify_flag), .modify_address(modify_address), .modify_data(modify_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic apply_vec(input vec_t v);
      @(posedge clk); #1;
      valid_i = v.valid; mem_op = v.op; modify_flag_i = v.flag;
      modify_address_i = v.rd; modify_data_i = v.data;
      @(negedge clk);
      chk("pt_flag", {31'd0, modify_flag}, {31'd0, v.exp_flag});
      chk("pt_rd", {27'd0, modify_address}, {27'd0, v.exp_rd});
      chk("pt_data", modify_data, v.exp_data);
      chk("pt_stall", {31'd0, stall_req}, 32'd0);
      chk("pt_req", {31'd0, ram_req}, 32'd0);
   endtask

   task automatic run_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input logic [31:0] rbytes, input int wait_idx,
                          input int wait_n, input logic [31:0] exp_data, input logic is_st);
      int n, k, waited, stalls, cyc;
      logic done;
      logic [31:0] sh, hold_addr;
      logic [7:0] hold_wd;
      xact_t x;
      wb_t w, got;
      n = (op == 4'd1 || op == 4'd4 || op == 4'd6) ? 1 :
          (op == 4'd2 || op == 4'd5 || op == 4'd7) ? 2 : 4;
      for (int i = 0; i < n; i++) begin
         sh = wdata >> (8 * i);
         x.wr = is_st; x.addr = addr + i; x.wdata = sh[7:0];
         xq.push_back(x);
      end
      w.flag = !is_st; w.rd = is_st ? 5'd0 : rd; w.data = exp_data;
      wbq.push_back(w);

      @(posedge clk); #1;
      valid_i = 1'b1; mem_op = op; mem_addr = addr; mem_wdata = wdata;
      modify_flag_i = 1'b1; modify_address_i = rd; modify_data_i = 32'h5555_AAAA;
      ram_ready = 1'b0;
      @(negedge clk);
      chk("acc_stall", {31'd0, stall_req}, 32'd1);
      chk("acc_req", {31'd0, ram_req}, 32'd0);
      chk("acc_flag", {31'd0, modify_flag}, 32'd0);
      stalls = 1; k = 0; waited = 0; done = 1'b0; cyc = 0;
      hold_addr = 32'd0; hold_wd = 8'd0;
      while (!done && cyc < 40) begin
         @(posedge clk); #1;
         sh = rbytes >> (8 * (k & 3));
         ram_rdata = sh[7:0];
         ram_ready = !(k == wait_idx && waited < wait_n);
         @(negedge clk);
         if (stall_req) stalls++;
         if (ram_req && !ram_ready) begin
            if (waited == 0) begin
               hold_addr = ram_addr; hold_wd = ram_wdata;
            end else begin
               chk("hold_addr", ram_addr, hold_addr);
               chk("hold_wdata", {24'd0, ram_wdata}, {24'd0, hold_wd});
            end
            waited++;
         end else if (ram_req && ram_ready) begin
            if (k == wait_idx && waited > 0) begin
               chk("hold_addr_end", ram_addr, hold_addr);
               chk("hold_wdata_end", {24'd0, ram_wdata}, {24'd0, hold_wd});
            end
            if (xq.size() == 0) begin
               chk("xq_empty", 32'd1, 32'd0);
            end else begin
               x = xq.pop_front();
               chk("ram_wr", {31'd0, ram_wr}, {31'd0, x.wr});
               chk("ram_addr", ram_addr, x.addr);
               chk("ram_wdata", {24'd0, ram_wdata}, {24'd0, x.wdata});
            end
            k++;
         end else if (!stall_req) begin
            done = 1'b1;
            chk("done_req", {31'd0, ram_req}, 32'd0);
            got = wbq.pop_front();
            chk("wb_flag", {31'd0, modify_flag}, {31'd0, got.flag});
            chk("wb_rd", {27'd0, modify_address}, {27'd0, got.rd});
            chk("wb_data", modify_data, got.data);
         end else begin
            chk("unexpected_idle_stall", 32'd1, 32'd0);
         end
         cyc++;
      end
      if (!done) chk("timeout", 32'd1, 32'd0);
      chk("stall_cycles", stalls, n + 1 + wait_n);
      chk("xq_drained", xq.size(), 32'd0);
      @(posedge clk); #1;
      valid_i = 1'b0; mem_op = 4'd0; ram_ready = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b1, 4'd0,  1'b1, 5'd5,  32'hDEAD_BEEF, 1'b1, 5'd5,  32'hDEAD_BEEF};
      vecs[1] = '{1'b1, 4'd12, 1'b1, 5'd31, 32'h1234_5678, 1'b1, 5'd31, 32'h1234_5678};
      vecs[2] = '{1'b0, 4'd0,  1'b1, 5'd7,  32'hFFFF_FFFF, 1'b0, 5'd0,  32'd0};
      vecs[3] = '{1'b1, 4'd0,  1'b0, 5'd9,  32'h0000_0001, 1'b0, 5'd9,  32'h0000_0001};
      vecs[4] = '{1'b1, 4'd15, 1'b1, 5'd0,  32'hCAFE_F00D, 1'b1, 5'd0,  32'hCAFE_F00D};

      rst = 1'b1; valid_i = 1'b1; mem_op = 4'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
      modify_flag_i = 1'b1; modify_address_i = 5'd5; modify_data_i = 32'hDEAD_BEEF;
      ram_rdata = 8'd0; ram_ready = 1'b0;
      #12;
      chk("rst_flag", {31'd0, modify_flag}, 32'd0);
      chk("rst_data", modify_data, 32'd0);
      chk("rst_stall", {31'd0, stall_req}, 32'd0);
      chk("rst_req", {31'd0, ram_req}, 32'd0);
      @(negedge clk); rst = 1'b0;

      foreach (vecs[i]) apply_vec(vecs[i]);

      run_mem(4'd3, 32'h0000_0100, 32'd0, 5'd3, 32'h4433_2211, -1, 0, 32'h4433_2211, 1'b0);
      run_mem(4'd1, 32'h0000_0020, 32'd0, 5'd4, 32'h0000_0080, -1, 0, 32'hFFFF_FF80, 1'b0);
      run_mem(4'd4, 32'h0000_0020, 32'd0, 5'd4, 32'h0000_0080, -1, 0, 32'h0000_0080, 1'b0);
      run_mem(4'd2, 32'h0000_0030, 32'd0, 5'd6, 32'h0000_9234, -1, 0, 32'hFFFF_9234, 1'b0);
      run_mem(4'd5, 32'h0000_0031, 32'd0, 5'd6, 32'h0000_9234, -1, 0, 32'h0000_9234, 1'b0);
      run_mem(4'd7, 32'hFFFF_FFFF, 32'hAABB_1234, 5'd8, 32'd0, -1, 0, 32'd0, 1'b1);
      run_mem(4'd8, 32'h0000_0200, 32'hA1B2_C3D4, 5'd9, 32'd0, 1, 3, 32'd0, 1'b1);
      run_mem(4'd6, 32'h0000_0300, 32'h0000_00E7, 5'd2, 32'd0, 0, 1, 32'd0, 1'b1);

      // LW abandoned by reset after two bytes.
      @(posedge clk); #1;
      valid_i = 1'b1; mem_op = 4'd3; mem_addr = 32'h0000_0400; modify_address_i = 5'd12;
      modify_flag_i = 1'b1; ram_ready = 1'b1; ram_rdata = 8'h77;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1; valid_i = 1'b0; mem_op = 4'd0;
      #1;
      chk("rstx_req", {31'd0, ram_req}, 32'd0);
      chk("rstx_stall", {31'd0, stall_req}, 32'd0);
      chk("rstx_flag", {31'd0, modify_flag}, 32'd0);
      @(negedge clk); rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("post_rst_flag", {31'd0, modify_flag}, 32'd0);
         chk("post_rst_req", {31'd0, ram_req}, 32'd0);
      end
      ram_ready = 1'b0;
      apply_vec(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
